// File: rtl/oc_alu_pkg.sv
// Shared opcode, flag and state definitions for the ones'-complement arithmetic unit.
package oc_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] PR_ZERO = 2'b00;
  localparam logic [1:0] PR_NEG  = 2'b01;
  localparam logic [1:0] PR_POS  = 2'b10;
  localparam logic [1:0] PR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/oc_adder.sv
// Combinational W-bit ones'-complement adder: the carry out of the MSB
// is folded back into the LSB (end-around carry).
module oc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);

  logic [W:0] raw;

  assign raw = {1'b0, x} + {1'b0, y};
  // A second carry cannot arise: raw[W-1:0] is never all ones when raw[W] is set.
  assign s   = raw[W-1:0] + {{(W-1){1'b0}}, raw[W]};

endmodule

// File: rtl/oc_alu_seq.sv
// Sequential ones'-complement add/sub/mul unit, N-bit operands, 2N-bit result.
// Add/sub finish 2 edges after start, mul after N, illegal opcode at once.
module oc_alu_seq
  import oc_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           set,
  input  logic           sno,
  input  logic [1:0]     cop,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] rr,
  output logic [1:0]     priznak,
  output logic           sko,
  output logic           busy
);

  localparam int             IW     = $clog2(N);
  localparam logic [IW-1:0]  I_LAST = IW'(N - 2);

  state_t          state;
  logic [N-1:0]    ra;
  logic [N-1:0]    rb;
  logic [1:0]      rc;
  logic [IW-1:0]   i;

  logic [2*N-1:0]  ext_a;
  logic [2*N-1:0]  ext_b;
  logic [2*N-1:0]  sum;
  logic [N-2:0]    ma;
  logic [N-2:0]    mb;
  logic [2*N-1:0]  mul_term;
  logic            sg;
  logic [2*N-1:0]  rr_fix;
  logic [1:0]      pr_next;

  // Add/sub operand path; subtraction negates by complementing the extended RB.
  assign ext_a = {{N{ra[N-1]}}, ra};
  assign ext_b = (rc == OP_SUB) ? ~{{N{rb[N-1]}}, rb} : {{N{rb[N-1]}}, rb};

  oc_adder #(.W(2 * N)) u_add (
    .x (ext_a),
    .y (ext_b),
    .s (sum)
  );

  // Multiply works on magnitudes; the sign is reapplied in FIX.
  assign ma       = ra[N-1] ? ~ra[N-2:0] : ra[N-2:0];
  assign mb       = rb[N-1] ? ~rb[N-2:0] : rb[N-2:0];
  assign sg       = ra[N-1] ^ rb[N-1];
  assign mul_term = (2 * N)'(ma) << i;

  always_comb begin
    rr_fix = rr;
    if (rc == OP_MUL) begin
      if (sg && (rr != '0)) rr_fix = ~rr;
    end else if (&rr) begin
      rr_fix = '0;
    end
    if (rr_fix == '0)            pr_next = PR_ZERO;
    else if (rr_fix[2*N-1])      pr_next = PR_NEG;
    else                         pr_next = PR_POS;
  end

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state   <= ST_IDLE;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      i       <= '0;
      rr      <= '0;
      priznak <= PR_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sno) begin
            ra <= a;
            rb <= b;
            rc <= cop;
            i  <= '0;
            rr <= '0;
            if (cop == OP_ILL) begin
              priznak <= PR_ILL;
              state   <= ST_DONE;
            end else begin
              state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (rc == OP_MUL) begin
            if (mb[i]) rr <= rr + mul_term;
            if (i == I_LAST) state <= ST_FIX;
            else             i     <= i + 1'b1;
          end else begin
            rr    <= sum;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          rr      <= rr_fix;
          priznak <= pr_next;
          state   <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sko  = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_oc_alu_seq.sv
// Randomised and directed checks of oc_alu_seq at N=4 and N=8 against an integer reference model.
module tb_oc_alu_seq;

  logic       clk = 1'b0;
  logic       set = 1'b1;

  logic       sno4 = 1'b0, sno8 = 1'b0;
  logic [1:0] cop4 = 2'b00, cop8 = 2'b00;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0]  rr4;
  logic [15:0] rr8;
  logic [1:0] pr4, pr8;
  logic       sko4, sko8, busy4, busy8;

  int n_chk = 0;
  int n_bad = 0;
  int sel   = 0;

  logic [15:0] rr_s;
  logic [1:0]  pr_s;
  logic        sko_s, busy_s;

  always #5 clk = ~clk;

  oc_alu_seq #(.N(4)) dut4 (
    .clk(clk), .set(set), .sno(sno4), .cop(cop4), .a(a4), .b(b4),
    .rr(rr4), .priznak(pr4), .sko(sko4), .busy(busy4)
  );

  oc_alu_seq #(.N(8)) dut8 (
    .clk(clk), .set(set), .sno(sno8), .cop(cop8), .a(a8), .b(b8),
    .rr(rr8), .priznak(pr8), .sko(sko8), .busy(busy8)
  );

  always_comb begin
    rr_s   = (sel == 1) ? rr8   : {8'h00, rr4};
    pr_s   = (sel == 1) ? pr8   : pr4;
    sko_s  = (sel == 1) ? sko8  : sko4;
    busy_s = (sel == 1) ? busy8 : busy4;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode ones' complement to integers, do plain arithmetic, re-encode.
  function automatic int oc_val(input logic [7:0] x, input int n);
    logic [7:0] mask;
    logic [7:0] mag;
    mask = 8'((16'd1 << n) - 16'd1);
    if (x[n-1]) begin
      mag = ~x & mask;
      return -int'(mag);
    end
    return int'(x & mask);
  endfunction

  function automatic logic [15:0] oc_enc(input int v, input int n);
    logic [15:0] mask;
    logic [15:0] m;
    mask = 16'((32'd1 << (2 * n)) - 32'd1);
    if (v >= 0) return 16'(v);
    m = 16'(-v);
    return ~m & mask;
  endfunction

  task automatic drive(input logic s, input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv);
    if (sel == 1) begin
      sno8 = s; cop8 = op; a8 = av; b8 = bv;
    end else begin
      sno4 = s; cop4 = op; a4 = av[3:0]; b4 = bv[3:0];
    end
  endtask

  // Called at posedge+1; leaves the selected DUT idle at posedge+1.
  task automatic do_op(input int d, input logic [1:0] op, input logic [7:0] av_in,
                       input logic [7:0] bv_in, input bit poke, output logic [15:0] got_rr);
    int n, lat, exp_lat, va, vb, r;
    logic [7:0]  av, bv;
    logic [15:0] e_rr;
    logic [1:0]  e_pr;
    bit seen;
    n   = (d == 1) ? 8 : 4;
    av  = (d == 1) ? av_in : {4'h0, av_in[3:0]};
    bv  = (d == 1) ? bv_in : {4'h0, bv_in[3:0]};
    va  = oc_val(av, n);
    vb  = oc_val(bv, n);
    case (op)
      2'b00:   r = va + vb;
      2'b01:   r = va - vb;
      default: r = va * vb;
    endcase
    if (op == 2'b11) begin
      e_rr = 16'h0; e_pr = 2'b11; exp_lat = 0;
    end else begin
      e_rr    = oc_enc(r, n);
      e_pr    = (r == 0) ? 2'b00 : (r < 0) ? 2'b01 : 2'b10;
      exp_lat = (op == 2'b10) ? n : 2;
    end
    sel = d;
    drive(1'b1, op, av, bv);
    @(posedge clk); #1;
    if (poke) drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    else      drive(1'b0, 2'b00, 8'h00, 8'h00);
    lat  = 0;
    seen = sko_s;
    if (!seen) chk("busy_running", int'(busy_s), 1);
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (poke) drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      seen = sko_s;
    end
    chk("sko_seen", int'(seen), 1);
    chk("latency", lat, exp_lat);
    chk("rr", int'(rr_s), int'(e_rr));
    chk("priznak", int'(pr_s), int'(e_pr));
    got_rr = rr_s;
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk("sko_one_cycle", int'(sko_s), 0);
    chk("busy_idle", int'(busy_s), 0);
    chk("rr_hold", int'(rr_s), int'(e_rr));
    chk("priznak_hold", int'(pr_s), int'(e_pr));
  endtask

  initial begin
    logic [15:0] got;
    #12;
    chk("rst_rr4", int'(rr4), 0);
    chk("rst_pr4", int'(pr4), 0);
    chk("rst_sko4", int'(sko4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_rr8", int'(rr8), 0);
    chk("rst_busy8", int'(busy8), 0);
    set = 1'b0;
    @(posedge clk); #1;

    do_op(0, 2'b00, 8'h03, 8'h0D, 1'b0, got);
    chk("add_4", int'(got), 32'h01);
    do_op(0, 2'b01, 8'h03, 8'h03, 1'b0, got);
    chk("sub_negzero_4", int'(got), 32'h00);
    do_op(0, 2'b10, 8'h03, 8'h0D, 1'b0, got);
    chk("mul_signed_4", int'(got), 32'hF9);
    do_op(0, 2'b10, 8'h0F, 8'h05, 1'b0, got);
    chk("mul_negzero_4", int'(got), 32'h00);
    do_op(1, 2'b10, 8'h7F, 8'h80, 1'b0, got);
    chk("mul_ext_neg_8", int'(got), 32'hC0FE);
    do_op(1, 2'b10, 8'h80, 8'h80, 1'b0, got);
    chk("mul_ext_pos_8", int'(got), 32'h3F01);
    do_op(0, 2'b11, 8'h05, 8'h06, 1'b0, got);
    chk("illegal_rr", int'(got), 0);
    do_op(1, 2'b10, 8'h35, 8'hC4, 1'b1, got);
    do_op(1, 2'b00, 8'h11, 8'h22, 1'b1, got);

    // Asynchronous reset while the N=8 multiply is at iteration 3.
    sel = 1;
    drive(1'b1, 2'b10, 8'h7F, 8'h7F);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #3 set = 1'b1;
    #1;
    chk("mid_rst_rr", int'(rr8), 0);
    chk("mid_rst_pr", int'(pr8), 0);
    chk("mid_rst_sko", int'(sko8), 0);
    chk("mid_rst_busy", int'(busy8), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_sko", int'(sko8), 0);
    end
    set = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(busy8), 0);
    do_op(1, 2'b00, 8'h05, 8'hFA, 1'b0, got);

    for (int k = 0; k < 120; k++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_op(int'($urandom_range(0, 1)), op, 8'($urandom), 8'($urandom),
            bit'($urandom_range(0, 5) == 0), got);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
